// File: rtl/slice_output_stage_if.sv
// rtl/slice_output_stage_if.sv - data and serial-config signals of the slice output stage
// Optional sclr signal is present only with SLICE_OUT_SYNC_CLR_EN defined.
interface slice_output_stage_if #(
  parameter int INPUTS = 4
);
  logic [INPUTS-1:0] S;
  logic              Co;
  logic [INPUTS-1:0] lut_out;
  logic              ce;
  logic              cfg_en;
  logic              cfg_in;
  logic              cfg_out;
  logic [INPUTS-1:0] out;
  logic              co_out;
  logic              cfg_done;
  logic              cfg_err;
`ifdef SLICE_OUT_SYNC_CLR_EN
  logic              sclr;
`endif

  modport master (
    output S, Co, lut_out, ce, cfg_en, cfg_in,
`ifdef SLICE_OUT_SYNC_CLR_EN
    output sclr,
`endif
    input  cfg_out, out, co_out, cfg_done, cfg_err
  );

  modport slave (
    input  S, Co, lut_out, ce, cfg_en, cfg_in,
`ifdef SLICE_OUT_SYNC_CLR_EN
    input  sclr,
`endif
    output cfg_out, out, co_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/slice_output_stage.sv
// rtl/slice_output_stage.sv - configurable slice output stage with serial config chain
// SLICE_OUT_SYNC_CLR_EN adds a synchronous clear (sclr) reloading the init values.
module slice_output_stage #(
  parameter int INPUTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slice_output_stage_if.slave  bus
);
  localparam int CFG_BITS = 3 * INPUTS + 1;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  localparam logic [1:0] ST_UNCONFIG = 2'd0;
  localparam logic [1:0] ST_LOADING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;

  logic [1:0]          state;
  logic [CFG_BITS-1:0] cfg_q;
  logic [CNT_W-1:0]    shift_cnt;
  logic                cfg_err_q;
  logic [INPUTS-1:0]   q;
  logic                co_q;

  logic [INPUTS-1:0]   sel_sum;
  logic [INPUTS-1:0]   reg_en;
  logic [INPUTS-1:0]   init;
  logic                co_reg_en;
  logic [INPUTS-1:0]   d;
  logic                active;
  logic                load_done;

  always_comb begin
    sel_sum   = '0;
    reg_en    = '0;
    init      = '0;
    co_reg_en = cfg_q[0];
    for (int i = 0; i < INPUTS; i++) begin
      sel_sum[i] = cfg_q[1 + 3 * i];
      reg_en[i]  = cfg_q[2 + 3 * i];
      init[i]    = cfg_q[3 + 3 * i];
    end
  end

  assign active    = (state == ST_ACTIVE);
  assign load_done = (state == ST_LOADING) && !bus.cfg_en && (shift_cnt == CNT_FULL);
  assign d         = (sel_sum & bus.S) | (~sel_sum & bus.lut_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (bus.cfg_en) begin
      cfg_q <= {bus.cfg_in, cfg_q[CFG_BITS-1:1]};
    end
  end

  // The shift that opens a load is counted, so the counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_UNCONFIG;
      shift_cnt <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      case (state)
        ST_UNCONFIG, ST_ACTIVE: begin
          if (bus.cfg_en) begin
            state     <= ST_LOADING;
            shift_cnt <= CNT_W'(1);
          end
        end
        ST_LOADING: begin
          if (bus.cfg_en) begin
            if (shift_cnt != CNT_FULL) begin
              shift_cnt <= shift_cnt + CNT_W'(1);
            end
          end else if (shift_cnt == CNT_FULL) begin
            state     <= ST_ACTIVE;
            cfg_err_q <= 1'b0;
          end else begin
            state     <= ST_UNCONFIG;
            cfg_err_q <= 1'b1;
          end
        end
        default: state <= ST_UNCONFIG;
      endcase
    end
  end

  // A reconfiguration request in ACTIVE takes priority over ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      co_q <= 1'b0;
    end else if (load_done) begin
      q    <= init;
      co_q <= 1'b0;
    end else if (active && !bus.cfg_en) begin
`ifdef SLICE_OUT_SYNC_CLR_EN
      if (bus.sclr) begin
        q    <= init;
        co_q <= 1'b0;
      end else
`endif
      if (bus.ce) begin
        q    <= d;
        co_q <= bus.Co;
      end
    end
  end

  assign bus.out      = active ? ((reg_en & q) | (~reg_en & d)) : '0;
  assign bus.co_out   = active ? (co_reg_en ? co_q : bus.Co) : 1'b0;
  assign bus.cfg_out  = cfg_q[0];
  assign bus.cfg_done = active;
  assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_slice_output_stage.sv
// tb/tb_slice_output_stage.sv - directed self-checking bench for slice_output_stage
module tb_slice_output_stage;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  slice_output_stage_if #(.INPUTS(4)) bus ();

  slice_output_stage #(.INPUTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk_cfg(input logic [3:0] sel, input logic [3:0] ren,
                                         input logic [3:0] ini, input logic co_ren);
    logic [12:0] w;
    w[0] = co_ren;
    for (int i = 0; i < 4; i++) begin
      w[1 + 3 * i] = sel[i];
      w[2 + 3 * i] = ren[i];
      w[3 + 3 * i] = ini[i];
    end
    return w;
  endfunction

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = w[i];
      tick();
    end
  endtask

  task automatic end_load();
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
    tick();
  endtask

  task automatic load_cfg(input logic [12:0] w);
    shift_bits({19'd0, w}, 13);
    end_load();
  endtask

  initial begin
    logic [25:0] pat;
    tests = 0;
    fails = 0;
    rst_n       = 1'b0;
    bus.S       = 4'hF;
    bus.Co      = 1'b1;
    bus.lut_out = 4'hF;
    bus.ce      = 1'b0;
    bus.cfg_en  = 1'b0;
    bus.cfg_in  = 1'b0;
`ifdef SLICE_OUT_SYNC_CLR_EN
    bus.sclr    = 1'b0;
`endif
    tick();
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_co_out", 32'(bus.co_out), 32'h0);
    check("rst_cfg_done", 32'(bus.cfg_done), 32'h0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
    check("rst_cfg_out", 32'(bus.cfg_out), 32'h0);

    rst_n = 1'b1;
    tick();
    tick();
    check("idle_unconfig", 32'(bus.cfg_done), 32'h0);

    // all-ones load: registered outputs show init=F, co_q cleared
    shift_bits(32'h1FFF, 6);
    check("loading_out_zero", 32'(bus.out), 32'h0);
    shift_bits(32'h7F, 7);
    end_load();
    check("ones_cfg_done", 32'(bus.cfg_done), 32'h1);
    check("ones_out", 32'(bus.out), 32'hF);
    check("ones_co_out", 32'(bus.co_out), 32'h0);
    check("ones_cfg_err", 32'(bus.cfg_err), 32'h0);

    // sum bypass, zero latency
    load_cfg(mk_cfg(4'hF, 4'h0, 4'h0, 1'b0));
    bus.S = 4'hA; bus.lut_out = 4'h5; bus.Co = 1'b1;
    #1;
    check("bypass_sum", 32'(bus.out), 32'hA);
    check("bypass_co", 32'(bus.co_out), 32'h1);
    bus.S = 4'h3; bus.Co = 1'b0;
    #1;
    check("bypass_sum2", 32'(bus.out), 32'h3);
    check("bypass_co2", 32'(bus.co_out), 32'h0);

    // registered LUT path with clock enable
    load_cfg(mk_cfg(4'h0, 4'hF, 4'h0, 1'b1));
    bus.lut_out = 4'h5; bus.ce = 1'b1; bus.Co = 1'b1;
    #1;
    check("reg_before_edge", 32'(bus.out), 32'h0);
    check("reg_co_before", 32'(bus.co_out), 32'h0);
    tick();
    check("reg_after_edge", 32'(bus.out), 32'h5);
    check("reg_co_after", 32'(bus.co_out), 32'h1);
    bus.ce = 1'b0; bus.lut_out = 4'h3; bus.Co = 1'b0;
    tick();
    check("reg_ce_hold", 32'(bus.out), 32'h5);
    check("reg_co_hold", 32'(bus.co_out), 32'h1);

    // cfg_en beats ce, then abort after 7 shifts
    bus.ce = 1'b1; bus.lut_out = 4'hA;
    shift_bits(32'h0, 1);
    check("cfg_wins_done", 32'(bus.cfg_done), 32'h0);
    check("cfg_wins_out", 32'(bus.out), 32'h0);
    shift_bits(32'h0, 6);
    end_load();
    check("abort_err", 32'(bus.cfg_err), 32'h1);
    check("abort_done", 32'(bus.cfg_done), 32'h0);
    check("abort_out", 32'(bus.out), 32'h0);
    bus.ce = 1'b0;
    tick();
    check("err_sticky", 32'(bus.cfg_err), 32'h1);
    shift_bits(32'h1FFF, 1);
    check("err_during_load", 32'(bus.cfg_err), 32'h1);
    shift_bits(32'hFFF, 12);
    end_load();
    check("reload_err", 32'(bus.cfg_err), 32'h0);
    check("reload_done", 32'(bus.cfg_done), 32'h1);
    check("reload_out", 32'(bus.out), 32'hF);

    // mixed map: sel=0011 reg_en=0101 init=0101 co_reg_en=1
    load_cfg(mk_cfg(4'b0011, 4'b0101, 4'b0101, 1'b1));
    bus.S = 4'b0101; bus.lut_out = 4'b0011; bus.Co = 1'b1;
    #1;
    check("mixed_out", 32'(bus.out), 32'h5);
    check("mixed_co", 32'(bus.co_out), 32'h0);
    bus.ce = 1'b1;
    tick();
    bus.ce = 1'b0;
    #1;
    check("mixed_out_reg", 32'(bus.out), 32'h1);
    check("mixed_co_reg", 32'(bus.co_out), 32'h1);

    // daisy chain: bit k reaches cfg_out 13 edges after it was shifted
    pat = 26'h2A5_9B35;
    for (int k = 0; k < 26; k++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = pat[k];
      tick();
      if (k >= 12 && k <= 24) check($sformatf("chain_bit%0d", k - 12), 32'(bus.cfg_out), 32'(pat[k - 12]));
    end
    end_load();
    check("chain_sat_done", 32'(bus.cfg_done), 32'h1);
    check("chain_sat_err", 32'(bus.cfg_err), 32'h0);

    // asynchronous reset pulse while ACTIVE
    load_cfg(13'h1FFF);
    check("pre_rst_out", 32'(bus.out), 32'hF);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(bus.out), 32'h0);
    check("async_rst_done", 32'(bus.cfg_done), 32'h0);
    check("async_rst_cfg_out", 32'(bus.cfg_out), 32'h0);
    #3;
    rst_n = 1'b1;

    // reset mid-load discards the partial config without raising cfg_err
    tick();
    shift_bits(32'h1F, 5);
    rst_n = 1'b0;
    bus.cfg_en = 1'b0;
    #1;
    check("midload_rst_err", 32'(bus.cfg_err), 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("midload_post_err", 32'(bus.cfg_err), 32'h0);
    check("midload_post_done", 32'(bus.cfg_done), 32'h0);
    check("midload_post_cfg_out", 32'(bus.cfg_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
